hub75_rx: RTL and testbench
===========================

// Module: hub75_rx
// PURPOSE
//  Receive side of the HUB75 link: oversamples the panel pins driven by hub75_output (hub75_clk,
//  hub75_rgb0/1, hub75_latch, hub75_OE, hub75_addr) on the system clock and rebuilds each latched row pair.
//  Presents it on a valid/ready port. Used for on-FPGA loopback self-test and as the panel model in benches.
// PARAMETERS
//  NUM_COLS     64  pixels shifted per row before each latch
//  ADDR_W       5   hub75_addr width (SCAN_RATE=32)
//  SYNC_STAGES  2   input synchronizer depth, >=1
//  OE_CNT_W     16  width of OE-on cycle counter
// PORTS
//  clk_in        in   1            system clock; hub75_clk must be <= clk_in/2 (high and low >= 1 cycle each)
//  rst_in        in   1            asynchronous, active-low reset
//  hub75_clk     in   1            panel shift clock; data taken on rising edge
//  hub75_rgb0    in   3            upper-half pixel bits {r,g,b}
//  hub75_rgb1    in   3            lower-half pixel bits
//  hub75_latch   in   1            row latch, rising edge = end of row
//  hub75_OE      in   1            output enable, active-low
//  hub75_addr    in   ADDR_W       row-pair address
//  row_data0     out  3*NUM_COLS   captured upper row; pixel k at [3k+2:3k]
//  row_data1     out  3*NUM_COLS   captured lower row
//  row_addr      out  ADDR_W       hub75_addr sampled at latch edge
//  row_oe_cycles out  OE_CNT_W     clk_in cycles with OE low since previous latch, saturating
//  row_err       out  1            bit count at latch != NUM_COLS
//  row_valid     out  1            output holds an unconsumed row
//  row_ready     in   1            consumer accepts when row_valid & row_ready
//  overrun_cnt   out  8            rows dropped because output was full; saturates at 255
// BEHAVIOUR
//  - All pin inputs pass through SYNC_STAGES flops; edge detect compares last stage to a 1-flop delayed copy.
//  - Reset (rst_in=0, any time): all outputs 0, pixel counter 0, shift buffers 0, OE counter 0, output FSM EMPTY.
//    Takes effect immediately (async); a partial row in progress is discarded.
//  - Pixel counter pix_cnt, width $clog2(NUM_COLS)+1, saturates at all-ones.
//  - hub75_clk rising edge: if pix_cnt<NUM_COLS store synced rgb0/rgb1 at index pix_cnt in buf0/buf1.
//    Always pix_cnt++ (saturating). Bits beyond NUM_COLS are discarded.
//  - OE counter: +1 each cycle synced OE==0, saturating at 2^OE_CNT_W-1.
//  - hub75_latch rising edge ("row end"): the clk-edge update of the same cycle is applied first, then
//    evaluate pix_cnt including that bit.
//    Candidate row = {buf0, buf1, synced addr, OE counter, err=(pix_cnt!=NUM_COLS)}.
//    Then pix_cnt<=0, buf0/buf1<=0, OE counter<=0 (an OE-low cycle coinciding with the edge counts for next row).
//  - Output FSM, 2 states:
//    EMPTY: row end -> load outputs, row_valid<=1, go FULL.
//    FULL: row_ready & !row end -> row_valid<=0, EMPTY.
//          row_ready & row end -> load new row, stay FULL (no drop).
//          !row_ready & row end -> keep old row, overrun_cnt++, stay FULL.
//  - Output registers are stable while row_valid=1 and not handshaken.
//  - Latency: row_valid rises on the SYNC_STAGES-th clk_in edge after the edge that first samples
//    hub75_latch high (edge 0).
//  - Latch with pix_cnt=0 still emits a row (all zero, row_err=1). Latch held high for many cycles = one row end.
//  - rgb/addr are sampled through the same synchronizer depth as the clock, so setup relative to hub75_clk is preserved.
// TESTING
//  1 64 pixels, px k rgb0=k%8, rgb1=7-k%8, addr=5, latch; row_ready=1 -> one beat, data match, row_addr=5, row_err=0.
//  2 63 clocks then latch -> row_err=1, pixel 63 = 0; 70 clocks then latch -> row_err=1, pixels 0..63 correct.
//  3 row_ready=0, three latched rows -> first row held unchanged, overrun_cnt=2; raise ready -> one beat, valid falls.
//  4 FULL, row_ready=1 in the same cycle as the second row end -> second row loaded, valid stays 1, overrun_cnt=0.
//  5 rst_in low after 30 pixels, release, 64 pixels + latch -> clean row, no stale bits, row_err=0.
//  6 OE low 100 cycles between latches -> row_oe_cycles=100; OE low 70000 cycles -> 65535.

Source files
------------

// File: rtl/hub75_rx.sv
// HUB75 receiver: oversamples panel pins on clk_in and rebuilds each latched row pair.
// Latency: row_valid rises SYNC_STAGES clk_in edges after latch is first sampled high.
// Backpressure: one-row output holding register; rows arriving while it is full and unaccepted are dropped and counted.
module hub75_rx #(
  parameter int NUM_COLS    = 64,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2,
  parameter int OE_CNT_W    = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   hub75_clk,
  input  logic [2:0]             hub75_rgb0,
  input  logic [2:0]             hub75_rgb1,
  input  logic                   hub75_latch,
  input  logic                   hub75_OE,
  input  logic [ADDR_W-1:0]      hub75_addr,
  output logic [3*NUM_COLS-1:0]  row_data0,
  output logic [3*NUM_COLS-1:0]  row_data1,
  output logic [ADDR_W-1:0]      row_addr,
  output logic [OE_CNT_W-1:0]    row_oe_cycles,
  output logic                   row_err,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [7:0]             overrun_cnt
);

  localparam int PW = 9 + ADDR_W;
  localparam int CW = $clog2(NUM_COLS) + 1;
  // OE idles deasserted (high) so the counter does not run while the synchronizer refills
  localparam logic [PW-1:0] SYNC_RST = {{(PW-ADDR_W-1){1'b0}}, 1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {EMPTY, FULL} state_t;

  logic [PW-1:0]          sync_q [SYNC_STAGES];
  logic                   s_clk, s_latch, s_oe, clk_d, latch_d;
  logic [2:0]             s_rgb0, s_rgb1;
  logic [ADDR_W-1:0]      s_addr;
  logic                   clk_rise, row_end, row_err_c, load, ovf;
  logic [CW-1:0]          pix_cnt, pix_upd;
  logic [3*NUM_COLS-1:0]  shift0, shift1, shift0_upd, shift1_upd;
  logic [OE_CNT_W-1:0]    oe_cnt, oe_upd;
  state_t                 state, state_nxt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      clk_d   <= 1'b0;
      latch_d <= 1'b0;
    end else begin
      sync_q[0] <= {hub75_clk, hub75_rgb0, hub75_rgb1, hub75_latch, hub75_OE, hub75_addr};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      clk_d   <= s_clk;
      latch_d <= s_latch;
    end
  end

  assign {s_clk, s_rgb0, s_rgb1, s_latch, s_oe, s_addr} = sync_q[SYNC_STAGES-1];
  assign clk_rise = s_clk & ~clk_d;
  assign row_end  = s_latch & ~latch_d;

  // Shift update for this cycle is folded in before a coincident row end is evaluated
  always_comb begin
    shift0_upd = shift0;
    shift1_upd = shift1;
    pix_upd    = pix_cnt;
    if (clk_rise) begin
      for (int k = 0; k < NUM_COLS; k++) begin
        if (pix_cnt == CW'(k)) begin
          shift0_upd[3*k +: 3] = s_rgb0;
          shift1_upd[3*k +: 3] = s_rgb1;
        end
      end
      if (pix_cnt != '1) pix_upd = pix_cnt + 1'b1;
    end
  end

  assign row_err_c = (pix_upd != CW'(NUM_COLS));
  assign oe_upd    = (!s_oe && oe_cnt != '1) ? oe_cnt + 1'b1 : oe_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pix_cnt <= '0;
      shift0  <= '0;
      shift1  <= '0;
      oe_cnt  <= '0;
    end else if (row_end) begin
      pix_cnt <= '0;
      shift0  <= '0;
      shift1  <= '0;
      oe_cnt  <= {{(OE_CNT_W-1){1'b0}}, ~s_oe};
    end else begin
      pix_cnt <= pix_upd;
      shift0  <= shift0_upd;
      shift1  <= shift1_upd;
      oe_cnt  <= oe_upd;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ovf       = 1'b0;
    case (state)
      EMPTY: begin
        if (row_end) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (row_end) begin
          load = row_ready;
          ovf  = ~row_ready;
        end else if (row_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign row_valid = (state == FULL);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      row_data0     <= '0;
      row_data1     <= '0;
      row_addr      <= '0;
      row_oe_cycles <= '0;
      row_err       <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      if (load) begin
        row_data0     <= shift0_upd;
        row_data1     <= shift1_upd;
        row_addr      <= s_addr;
        row_oe_cycles <= oe_cnt;
        row_err       <= row_err_c;
      end
      if (ovf && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: directed rows against a row-level expectation model plus literal spot checks.
module tb_hub75_rx;

  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst_in = 1'b0;
  logic         hub_clk = 1'b0;
  logic [2:0]   rgb0 = '0, rgb1 = '0;
  logic         latch = 1'b0;
  logic         oe = 1'b1;
  logic [4:0]   addr = '0;
  logic [191:0] row_data0, row_data1;
  logic [4:0]   row_addr;
  logic [15:0]  row_oe_cycles;
  logic         row_err, row_valid;
  logic         row_ready = 1'b0;
  logic [7:0]   overrun_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int           due;
    logic [191:0] d0;
    logic [191:0] d1;
    logic [4:0]   addr;
    logic [15:0]  oe;
    logic         err;
  } row_t;

  row_t pend[$];
  row_t mrow;
  row_t nr;
  bit   mvalid = 0;
  bit   re;
  int   movr = 0;

  hub75_rx dut (
    .clk_in(clk), .rst_in(rst_in), .hub75_clk(hub_clk), .hub75_rgb0(rgb0), .hub75_rgb1(rgb1),
    .hub75_latch(latch), .hub75_OE(oe), .hub75_addr(addr), .row_data0(row_data0), .row_data1(row_data1),
    .row_addr(row_addr), .row_oe_cycles(row_oe_cycles), .row_err(row_err), .row_valid(row_valid),
    .row_ready(row_ready), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [191:0] exp_data(input int n, input int seed, input bit lower);
    logic [191:0] v;
    v = '0;
    for (int k = 0; k < 64; k++)
      if (k < n) v[3*k +: 3] = lower ? 3'(7 - (k + seed) % 8) : 3'((k + seed) % 8);
    return v;
  endfunction

  // Row-level model: each latch delivers one row SYNC+1 edges after it is driven
  always @(posedge clk) begin
    cyc++;
    if (!rst_in) begin
      pend.delete();
      mvalid = 0;
      movr   = 0;
    end else begin
      re = (pend.size() > 0) && (pend[0].due <= cyc);
      if (re) nr = pend.pop_front();
      if (mvalid) begin
        if (re) begin
          if (row_ready) mrow = nr;
          else if (movr < 255) movr++;
        end else if (row_ready) mvalid = 0;
      end else if (re) begin
        mrow   = nr;
        mvalid = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_in) begin
      chk("valid", {191'd0, row_valid}, {191'd0, mvalid});
      chk("overrun", {184'd0, overrun_cnt}, 192'(movr));
      if (mvalid) begin
        chk("data0", row_data0, mrow.d0);
        chk("data1", row_data1, mrow.d1);
        chk("addr", {187'd0, row_addr}, {187'd0, mrow.addr});
        chk("oe_cycles", {176'd0, row_oe_cycles}, {176'd0, mrow.oe});
        chk("err", {191'd0, row_err}, {191'd0, mrow.err});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic shift(input int n, input int seed);
    for (int k = 0; k < n; k++) begin
      hub_clk = 1'b0;
      rgb0 = 3'((k + seed) % 8);
      rgb1 = 3'(7 - (k + seed) % 8);
      tick(1);
      hub_clk = 1'b1;
      tick(1);
    end
    hub_clk = 1'b0;
    tick(1);
  endtask

  task automatic send_row(input int n, input int seed, input logic [4:0] a, input int oe_low,
                          input int hold, input bit pulse_ready);
    row_t r;
    addr = a;
    shift(n, seed);
    if (oe_low > 0) begin
      oe = 1'b0;
      tick(oe_low);
      oe = 1'b1;
      tick(1);
    end
    r.due  = cyc + 1 + SYNC;
    r.d0   = exp_data(n, seed, 0);
    r.d1   = exp_data(n, seed, 1);
    r.addr = a;
    r.oe   = (oe_low > 65535) ? 16'hffff : 16'(oe_low);
    r.err  = (n != 64);
    pend.push_back(r);
    latch = 1'b1;
    if (pulse_ready) begin
      while (cyc < r.due - 1) tick(1);
      row_ready = 1'b1;
      tick(1);
      row_ready = 1'b0;
    end
    tick(hold);
    latch = 1'b0;
    tick(3);
  endtask

  task automatic consume();
    row_ready = 1'b1;
    tick(1);
    row_ready = 1'b0;
    tick(1);
    chk("valid_after_consume", {191'd0, row_valid}, 192'd0);
  endtask

  initial begin
    tick(3);
    chk("rst_valid", {191'd0, row_valid}, 192'd0);
    chk("rst_overrun", {184'd0, overrun_cnt}, 192'd0);
    chk("rst_data0", row_data0, 192'd0);
    chk("rst_oe", {176'd0, row_oe_cycles}, 192'd0);
    rst_in = 1'b1;
    tick(2);

    // full row, addr 5
    send_row(64, 0, 5'd5, 0, 2, 0);
    chk("t1_valid", {191'd0, row_valid}, 192'd1);
    chk("t1_addr", {187'd0, row_addr}, 192'd5);
    chk("t1_err", {191'd0, row_err}, 192'd0);
    chk("t1_px10_0", {189'd0, row_data0[32:30]}, 192'd2);
    chk("t1_px10_1", {189'd0, row_data1[32:30]}, 192'd5);
    chk("t1_px63_0", {189'd0, row_data0[191:189]}, 192'd7);
    consume();

    // short row and long row
    send_row(63, 0, 5'd6, 0, 2, 0);
    chk("t2_err_short", {191'd0, row_err}, 192'd1);
    chk("t2_px62", {189'd0, row_data0[188:186]}, 192'd6);
    chk("t2_px63", {186'd0, row_data1[191:189], row_data0[191:189]}, 192'd0);
    consume();
    send_row(70, 3, 5'd7, 0, 2, 0);
    chk("t2_err_long", {191'd0, row_err}, 192'd1);
    chk("t2_long_px0", {189'd0, row_data0[2:0]}, 192'd3);
    chk("t2_long_px63", {189'd0, row_data0[191:189]}, 192'd2);
    consume();

    // empty row with latch held for a long time
    send_row(0, 0, 5'd1, 0, 20, 0);
    chk("empty_err", {191'd0, row_err}, 192'd1);
    chk("empty_data", row_data0, 192'd0);
    consume();
    tick(4);
    chk("single_row_end", {191'd0, row_valid}, 192'd0);

    // three rows without ready
    send_row(64, 1, 5'd8, 0, 2, 0);
    send_row(64, 2, 5'd9, 0, 2, 0);
    send_row(64, 3, 5'd10, 0, 2, 0);
    chk("t3_overrun", {184'd0, overrun_cnt}, 192'd2);
    chk("t3_addr_held", {187'd0, row_addr}, 192'd8);
    chk("t3_px0_held", {189'd0, row_data0[2:0]}, 192'd1);
    consume();

    // ready coincident with second row end
    rst_in = 1'b0;
    tick(2);
    rst_in = 1'b1;
    tick(2);
    chk("t4_overrun_clr", {184'd0, overrun_cnt}, 192'd0);
    send_row(64, 4, 5'd11, 0, 2, 0);
    send_row(64, 5, 5'd12, 0, 2, 1);
    chk("t4_valid", {191'd0, row_valid}, 192'd1);
    chk("t4_addr", {187'd0, row_addr}, 192'd12);
    chk("t4_overrun", {184'd0, overrun_cnt}, 192'd0);
    consume();

    // reset mid-row
    shift(30, 2);
    rst_in = 1'b0;
    tick(2);
    chk("t5_rst_valid", {191'd0, row_valid}, 192'd0);
    rst_in = 1'b1;
    tick(2);
    send_row(64, 6, 5'd13, 0, 2, 0);
    chk("t5_err", {191'd0, row_err}, 192'd0);
    chk("t5_px0", {189'd0, row_data0[2:0]}, 192'd6);
    consume();

    // OE-low cycle counting
    send_row(64, 0, 5'd14, 100, 2, 0);
    chk("t6_oe100", {176'd0, row_oe_cycles}, 192'd100);
    consume();
    send_row(64, 0, 5'd15, 70000, 2, 0);
    chk("t6_oe_sat", {176'd0, row_oe_cycles}, 192'd65535);
    consume();

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
